vdp_super_res_writer: RTL

//   Write-side companion to the super-res display fetch. Accepts pixel writes (x, y, 24-bit RGB) from the

---
 rtl/vdp_super_res_writer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vdp_super_res_writer.sv
// Super-res pixel write packer: packs (x, y, RGB) into the super_color / super_mid VRAM layouts,
// queues packed words and issues byte-enabled 32-bit VRAM writes when the display leaves the slot free.
module vdp_super_res_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  super_color,
  input  logic                  super_mid,
  input  logic                  pal_mode,
  input  logic                  slot_free,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic [23:0]           pix_rgb,
  output logic                  vram_wr_req,
  input  logic                  vram_wr_ack,
  output logic [ADDR_WIDTH-1:0] vram_wr_addr,
  output logic [31:0]           vram_wr_data,
  output logic [3:0]            vram_wr_be,
  output logic                  dropped,
  output logic                  busy
);
  // state | meaning
  // IDLE  | no write outstanding, waiting for a queued entry and a free slot
  // REQ   | head entry presented on the VRAM port, held until ack

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int IW = (ADDR_WIDTH > 22) ? ADDR_WIDTH : 22;

  typedef enum logic {IDLE, REQ} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [3:0]            fifo_be   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]         count;
  logic                  ready_en;

  logic [IW-1:0]         y_ext, x_ext, y180, lin_color, lin_mid;
  logic [ADDR_WIDTH-1:0] pack_addr;
  logic [31:0]           pack_data;
  logic [3:0]            pack_be;
  logic [15:0]           p565;
  logic                  color_ok, mid_ok, pack_ok, accept, push, pop;

  // y*180 by shift-add; y*360 is the same product doubled
  assign y_ext     = IW'(pix_y);
  assign x_ext     = IW'(pix_x);
  assign y180      = (y_ext << 7) + (y_ext << 5) + (y_ext << 4) + (y_ext << 2);
  assign lin_color = (y180 + x_ext) << 2;
  assign lin_mid   = ((y180 << 1) + x_ext) << 1;
  assign p565      = {pix_rgb[15:10], pix_rgb[23:19], pix_rgb[7:3]};

  assign color_ok = (pix_x < 10'd180) && (pix_y < (pal_mode ? 10'd144 : 10'd120));
  assign mid_ok   = (pix_x < 10'd360) && (pix_y < (pal_mode ? 10'd288 : 10'd240));

  always_comb begin
    pack_addr = '0;
    pack_data = '0;
    pack_be   = '0;
    pack_ok   = 1'b0;
    if (super_color) begin
      pack_ok   = color_ok;
      pack_addr = ADDR_WIDTH'(lin_color);
      pack_data = {8'h00, pix_rgb};
      pack_be   = 4'b1111;
    end else if (super_mid) begin
      pack_ok   = mid_ok;
      pack_addr = ADDR_WIDTH'(lin_mid) & ~ADDR_WIDTH'(3);
      pack_data = pix_x[0] ? {p565, 16'h0000} : {16'h0000, p565};
      pack_be   = pix_x[0] ? 4'b1100 : 4'b0011;
    end
  end

  assign pix_ready = ready_en && (count < CW'(FIFO_DEPTH));
  assign accept    = pix_valid && pix_ready;
  assign push      = accept && pack_ok;
  assign pop       = (state == REQ) && vram_wr_ack;
  assign rd_next   = rd_ptr + PW'(1);
  assign busy      = (count != '0) || vram_wr_req;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= pack_addr;
      fifo_data[wr_ptr] <= pack_data;
      fifo_be[wr_ptr]   <= pack_be;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      dropped  <= accept && !pack_ok;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_next;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // The head stays in the FIFO while presented; a back-to-back issue needs a second entry behind it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      vram_wr_req  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      vram_wr_be   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((count != '0) && slot_free) begin
            state        <= REQ;
            vram_wr_req  <= 1'b1;
            vram_wr_addr <= fifo_addr[rd_ptr];
            vram_wr_data <= fifo_data[rd_ptr];
            vram_wr_be   <= fifo_be[rd_ptr];
          end
        end
        REQ: begin
          if (vram_wr_ack) begin
            if ((count > CW'(1)) && slot_free) begin
              vram_wr_addr <= fifo_addr[rd_next];
              vram_wr_data <= fifo_data[rd_next];
              vram_wr_be   <= fifo_be[rd_next];
            end else begin
              state       <= IDLE;
              vram_wr_req <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          vram_wr_req <= 1'b0;
        end
      endcase
    end
  end
endmodule
